exec_unit: RTL and testbench

Execute stage of the 8-bit datapath, directly downstream of the register bank. Takes the two operands read from the bank plus an opcode and destination index, computes the result (single-cycle logic/arithmetic or an 8-cycle shift-add multiply), and drives the bank's write port (destination index, data, write enable) for exactly one cycle per operation. It also produces zero and carry flags for the sequencer.

---
 rtl/exec_unit_if.sv | 26 ++
 rtl/exec_unit.sv | 128 ++++++++++++
 tb/tb_exec_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_if.sv
// exec_unit_if: request/result bundle between the sequencer/register bank and exec_unit.
// master = upstream driver (sequencer side), slave = exec_unit.
interface exec_unit_if;
    logic       cen;
    logic       start;
    logic [2:0] op;
    logic [2:0] rd_i;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy;
    logic       we_o;
    logic [2:0] rd_o;
    logic [7:0] dat_o;
    logic       z_o;
    logic       c_o;

    modport master (
        output cen, start, op, rd_i, a_i, b_i,
        input  busy, we_o, rd_o, dat_o, z_o, c_o
    );

    modport slave (
        input  cen, start, op, rd_i, a_i, b_i,
        output busy, we_o, rd_o, dat_o, z_o, c_o
    );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: 8-bit execute stage, single-cycle ALU ops plus a write-back cycle to the bank.
// Define EXEC_MUL_EN to build the 8-cycle shift-add multiplier; otherwise op 110 passes a_i.
module exec_unit (
    input  logic       clk,
    input  logic       rst,
    exec_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd2;
`ifdef EXEC_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
`endif

    logic [1:0] state;
    logic [2:0] rd_q;
    logic [7:0] dat_q;
    logic       z_q;
    logic       c_q;

    // Single-cycle result, computed straight from the operands at accept time.
    logic [7:0]  alu_d;
    logic        alu_c;
    logic [8:0]  sum;
    logic [15:0] shl;

    always_comb begin
        alu_d = 8'd0;
        alu_c = 1'b0;
        sum   = 9'd0;
        shl   = 16'd0;
        case (bus.op)
            3'b000: begin
                sum   = {1'b0, bus.a_i} + {1'b0, bus.b_i};
                alu_d = sum[7:0];
                alu_c = sum[8];
            end
            3'b001: begin
                // 9-bit difference: bit 8 is the unsigned borrow
                sum   = {1'b0, bus.a_i} - {1'b0, bus.b_i};
                alu_d = sum[7:0];
                alu_c = sum[8];
            end
            3'b010: alu_d = bus.a_i & bus.b_i;
            3'b011: alu_d = bus.a_i | bus.b_i;
            3'b100: alu_d = bus.a_i ^ bus.b_i;
            3'b101: begin
                shl   = {8'd0, bus.a_i} << bus.b_i[2:0];
                alu_d = shl[7:0];
                alu_c = |shl[15:8];
            end
            3'b110:  alu_d = bus.a_i;
            default: alu_d = bus.b_i;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [2:0]  mrd_q;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic [15:0] mul_nxt;

    // One multiplier bit per enabled cycle, LSB first.
    assign mul_nxt = acc + (b_q[cnt] ? ({8'd0, a_q} << cnt) : 16'd0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            rd_q  <= 3'd0;
            dat_q <= 8'd0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
`ifdef EXEC_MUL_EN
            a_q   <= 8'd0;
            b_q   <= 8'd0;
            mrd_q <= 3'd0;
            acc   <= 16'd0;
            cnt   <= 3'd0;
`endif
        end else if (bus.cen) begin
            case (state)
                S_IDLE: if (bus.start) begin
`ifdef EXEC_MUL_EN
                    if (bus.op == 3'b110) begin
                        a_q   <= bus.a_i;
                        b_q   <= bus.b_i;
                        mrd_q <= bus.rd_i;
                        acc   <= 16'd0;
                        cnt   <= 3'd0;
                        state <= S_MUL;
                    end else
`endif
                    begin
                        dat_q <= alu_d;
                        c_q   <= alu_c;
                        z_q   <= (alu_d == 8'd0);
                        rd_q  <= bus.rd_i;
                        state <= S_WB;
                    end
                end
`ifdef EXEC_MUL_EN
                S_MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        dat_q <= mul_nxt[7:0];
                        c_q   <= |mul_nxt[15:8];
                        z_q   <= (mul_nxt[7:0] == 8'd0);
                        rd_q  <= mrd_q;
                        state <= S_WB;
                    end
                end
`endif
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (state != S_IDLE);
    assign bus.we_o  = (state == S_WB);
    assign bus.rd_o  = rd_q;
    assign bus.dat_o = dat_q;
    assign bus.z_o   = z_q;
    assign bus.c_o   = c_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed + random operations checked against an arithmetic reference model.
// Model follows EXEC_MUL_EN the same way the design build does.
module tb_exec_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    exec_unit_if ifc();

    exec_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: result, flags, and enabled edges between accept and write-back.
    task automatic model(input logic [2:0] o, input int a, input int b,
                         output int d, output bit z, output bit c, output int lat);
        int full;
        full = 0;
        c    = 1'b0;
        lat  = 0;
        case (o)
            3'd0: begin full = a + b; c = (full > 255); end
            3'd1: begin full = a - b; c = (a < b); end
            3'd2: full = a & b;
            3'd3: full = a | b;
            3'd4: full = a ^ b;
            3'd5: begin full = a << (b % 8); c = ((full >> 8) != 0); end
            3'd6: begin
`ifdef EXEC_MUL_EN
                full = a * b;
                c    = ((full >> 8) != 0);
                lat  = 8;
`else
                full = a;
`endif
            end
            default: full = b;
        endcase
        d = full & 255;
        z = (d == 0);
    endtask

    // mode 0: cen always high; 1: random cen gaps; 2: 4-cycle stall mid-op.
    // mode != 0 also freezes write-back for two cycles. poke re-requests an ADD while busy.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] r, input int mode, input bit poke);
        int  ed, lat, en_cnt, guard;
        bit  ez, ec;
        model(o, a, b, ed, ez, ec, lat);
        @(negedge clk);
        chk("idle_busy", ifc.busy, 0);
        ifc.cen   = 1'b1;
        ifc.start = 1'b1;
        ifc.op    = o;
        ifc.a_i   = a;
        ifc.b_i   = b;
        ifc.rd_i  = r;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.op    = 3'($urandom);
        ifc.a_i   = 8'($urandom);
        ifc.b_i   = 8'($urandom);
        ifc.rd_i  = 3'($urandom);
        en_cnt = 0;
        guard  = 0;
        while (guard < 100) begin
            @(negedge clk);
            ifc.start = 1'b0;
            if (ifc.we_o) break;
            chk("busy_op", ifc.busy, 1);
            if (poke && guard == 2) begin
                ifc.start = 1'b1;
                ifc.op    = 3'd0;
            end
            case (mode)
                1:       ifc.cen = ($urandom_range(0, 3) != 0);
                2:       ifc.cen = !(guard >= 3 && guard <= 6);
                default: ifc.cen = 1'b1;
            endcase
            guard++;
            @(posedge clk);
            if (ifc.cen) en_cnt++;
        end
        if (guard >= 100) chk("timeout_we", 0, 1);
        chk("we",      ifc.we_o,  1);
        chk("latency", 16'(en_cnt), 16'(lat));
        chk("dat",     ifc.dat_o, 16'(ed));
        chk("rd",      ifc.rd_o,  r);
        chk("z",       ifc.z_o,   ez);
        chk("c",       ifc.c_o,   ec);
        if (mode != 0) begin
            ifc.cen = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("wb_hold", ifc.we_o, 1);
        end
        ifc.cen = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("we_drop",  ifc.we_o,  0);
        chk("busy_end", ifc.busy,  0);
        chk("dat_hold", ifc.dat_o, 16'(ed));
        chk("rd_hold",  ifc.rd_o,  r);
        @(negedge clk);
        chk("one_pulse", ifc.we_o, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, ifc.busy,  0);
        chk({tag, "_we"},   ifc.we_o,  0);
        chk({tag, "_rd"},   ifc.rd_o,  0);
        chk({tag, "_dat"},  ifc.dat_o, 0);
        chk({tag, "_z"},    ifc.z_o,   0);
        chk({tag, "_c"},    ifc.c_o,   0);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b0;
        ifc.cen   = 1'b0;
        ifc.start = 1'b0;
        ifc.op    = 3'd0;
        ifc.rd_i  = 3'd0;
        ifc.a_i   = 8'd0;
        ifc.b_i   = 8'd0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst     = 1'b1;
        ifc.cen = 1'b1;

        run_op(3'd0, 8'd200, 8'd100, 3'd3, 0, 1'b0);
        run_op(3'd1, 8'd5,   8'd5,   3'd1, 0, 1'b0);
        run_op(3'd1, 8'd3,   8'd7,   3'd2, 0, 1'b0);
        run_op(3'd5, 8'd129, 8'd0,   3'd4, 0, 1'b0);
        run_op(3'd5, 8'd129, 8'd7,   3'd5, 0, 1'b0);
        run_op(3'd7, 8'd9,   8'd0,   3'd7, 0, 1'b0);
        run_op(3'd6, 8'd13,  8'd11,  3'd6, 0, 1'b0);
        run_op(3'd6, 8'd16,  8'd16,  3'd0, 0, 1'b0);
        run_op(3'd6, 8'd13,  8'd11,  3'd6, 0, 1'b1);
        run_op(3'd6, 8'd13,  8'd11,  3'd6, 2, 1'b0);

        // Reset during the multiply: outputs clear at once and nothing is written.
        @(negedge clk);
        ifc.cen   = 1'b1;
        ifc.start = 1'b1;
        ifc.op    = 3'd6;
        ifc.a_i   = 8'd13;
        ifc.b_i   = 8'd11;
        ifc.rd_i  = 3'd6;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_we", ifc.we_o, 0);
        end
        run_op(3'd0, 8'd1, 8'd1, 3'd2, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
                   int'($urandom_range(0, 1)), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
